// File: rtl/pe_traffic_gen_if.sv
// Local-port bundle between a processing element and its router.
// The master side is the PE. The slave side is the router.
interface pe_traffic_gen_if #(
    parameter int unsigned TOTAL_WIDTH = 36
);
    logic [TOTAL_WIDTH-1:0] o_data;
    logic                   o_data_valid;
    logic                   i_data_ready;
    logic [TOTAL_WIDTH-1:0] i_data;
    logic                   i_data_valid;
    logic                   o_data_ready;

    modport master (
        output o_data, o_data_valid, o_data_ready,
        input  i_data_ready, i_data, i_data_valid
    );

    modport slave (
        input  o_data, o_data_valid, o_data_ready,
        output i_data_ready, i_data, i_data_valid
    );
endinterface

// File: rtl/pe_traffic_gen.sv
// NoC processing-element endpoint. It injects a programmed burst of packets toward the router.
// It also sinks, counts and checks every packet that arrives from the router.
//
// state  | meaning
// S_IDLE | waiting for the first i_start after reset
// S_SEND | packet presented with valid high, waiting for the router to accept it
// S_GAP  | idle cycles between an accepted packet and the next one
// S_DONE | run complete, o_done high, i_start starts a new run
module pe_traffic_gen #(
    parameter int unsigned ADDRESS       = 0,
    parameter int unsigned NUM_PE        = 16,
    parameter int unsigned ADDRESS_WIDTH = 4,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned TOTAL_WIDTH   = 36,
    parameter int unsigned PKT_LIMIT     = 100,
    parameter int unsigned INJ_GAP       = 0,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [1:0]               i_mode,
    input  logic [ADDRESS_WIDTH-1:0] i_dest,
    pe_traffic_gen_if.master         noc,
    output logic                     o_done,
    output logic [CNT_WIDTH-1:0]     o_sent_count,
    output logic [CNT_WIDTH-1:0]     o_recv_count,
    output logic [CNT_WIDTH-1:0]     o_err_count
);

    localparam int unsigned SEQ_W = (PKT_LIMIT == 0) ? 1 : $clog2(PKT_LIMIT + 1);
    localparam int unsigned GAP_W = (INJ_GAP == 0) ? 1 : $clog2(INJ_GAP + 1);

    localparam logic [15:0]              SEED_MIX  = LFSR_SEED ^ 16'(ADDRESS);
    // An all-zero Galois LFSR locks up, so that one seed value is replaced.
    localparam logic [15:0]              LFSR_INIT = (SEED_MIX == 16'h0000) ? 16'h0001 : SEED_MIX;
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_HDR  = ADDRESS_WIDTH'(ADDRESS);
    localparam logic [ADDRESS_WIDTH-1:0] NEIGH_HDR = ADDRESS_WIDTH'((ADDRESS + 1) % NUM_PE);
    localparam logic [DATA_WIDTH-1:0]    PAY_BASE  = DATA_WIDTH'(PKT_LIMIT * ADDRESS);
    localparam logic [SEQ_W-1:0]         SEQ_LAST  = SEQ_W'(PKT_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [TOTAL_WIDTH-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic [CNT_WIDTH-1:0]   sent_q, sent_d;
    logic [CNT_WIDTH-1:0]   recv_q, recv_d;
    logic [CNT_WIDTH-1:0]   err_q, err_d;
    logic [SEQ_W-1:0]       seq_q, seq_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic                   accept;
    logic                   unused_payload;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    function automatic logic [TOTAL_WIDTH-1:0] form_pkt(
        input logic [SEQ_W-1:0]         seq,
        input logic [15:0]              lfsr,
        input logic [1:0]               mode,
        input logic [ADDRESS_WIDTH-1:0] dest
    );
        logic [ADDRESS_WIDTH-1:0] hdr;
        case (mode)
            2'd1:    hdr = dest;
            2'd2:    hdr = NEIGH_HDR;
            default: hdr = ADDRESS_WIDTH'(lfsr % 16'(NUM_PE));
        endcase
        return TOTAL_WIDTH'({hdr, PAY_BASE + DATA_WIDTH'(seq)});
    endfunction

    assign accept = valid_q && noc.i_data_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        sent_d  = sent_q;
        recv_d  = recv_q;
        err_d   = err_q;
        seq_d   = seq_q;
        lfsr_d  = lfsr_q;
        gap_d   = gap_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    sent_d = '0;
                    seq_d  = '0;
                    if (PKT_LIMIT == 0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SEND;
                        valid_d = 1'b1;
                        data_d  = form_pkt('0, lfsr_q, i_mode, i_dest);
                    end
                end
            end
            S_SEND: begin
                if (accept) begin
                    sent_d = sat_inc(sent_q);
                    seq_d  = seq_q + SEQ_W'(1);
                    lfsr_d = lfsr_step(lfsr_q);
                    if (seq_d == SEQ_LAST) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                    end else if (INJ_GAP == 0) begin
                        data_d = form_pkt(seq_d, lfsr_d, i_mode, i_dest);
                    end else begin
                        state_d = S_GAP;
                        valid_d = 1'b0;
                        gap_d   = GAP_W'(INJ_GAP);
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(1)) begin
                    state_d = S_SEND;
                    valid_d = 1'b1;
                    data_d  = form_pkt(seq_q, lfsr_q, i_mode, i_dest);
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        done_d = (state_d == S_DONE);

        // The receive path runs independently of the transmit state machine.
        if (noc.i_data_valid) begin
            recv_d = sat_inc(recv_q);
            if (noc.i_data[DATA_WIDTH +: ADDRESS_WIDTH] != ADDR_HDR) begin
                err_d = sat_inc(err_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            sent_q  <= '0;
            recv_q  <= '0;
            err_q   <= '0;
            seq_q   <= '0;
            lfsr_q  <= LFSR_INIT;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            sent_q  <= sent_d;
            recv_q  <= recv_d;
            err_q   <= err_d;
            seq_q   <= seq_d;
            lfsr_q  <= lfsr_d;
            gap_q   <= gap_d;
        end
    end

    assign noc.o_data       = data_q;
    assign noc.o_data_valid = valid_q;
    assign noc.o_data_ready = 1'b1;
    assign o_done           = done_q;
    assign o_sent_count     = sent_q;
    assign o_recv_count     = recv_q;
    assign o_err_count      = err_q;

    assign unused_payload = ^noc.i_data[DATA_WIDTH-1:0];

endmodule

// File: doc/pe_traffic_gen.md
Name: pe_traffic_gen

Overview:
- Synthesizable, parametrised NoC processing-element endpoint that replaces the behavioural PE model.
- Injects a programmable number of packets with selectable destination mode and a programmable inter-packet gap.
- Sinks all incoming packets, counts them, and flags packets that arrive at the wrong PE.
- Sits at each router local port; a top-level controller starts it and reads its counters.

Parameters:
ADDRESS, 0, this PE's network address
NUM_PE, 16, number of PEs; legal destinations 0..NUM_PE-1 (NUM_PE <= 2**ADDRESS_WIDTH)
ADDRESS_WIDTH, 4, destination header width
DATA_WIDTH, 32, payload width
TOTAL_WIDTH, 36, packet width; must equal ADDRESS_WIDTH+DATA_WIDTH
PKT_LIMIT, 100, packets injected per run
INJ_GAP, 0, idle cycles between an accepted packet and the next valid
LFSR_SEED, 16'hACE1, base seed for the destination LFSR
CNT_WIDTH, 16, width of the statistics counters

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low
i_start  input  1  single-cycle pulse; starts a run (honoured in IDLE/DONE only)
i_mode  input  2  0 = uniform random, 1 = fixed i_dest, 2 = neighbour (ADDRESS+1)%NUM_PE, 3 = reserved (treated as 0)
i_dest  input  ADDRESS_WIDTH  destination used in mode 1
o_data  output  TOTAL_WIDTH  outgoing packet {dest, payload}
o_data_valid  output  1  outgoing packet valid
i_data_ready  input  1  router accepts outgoing packet
i_data  input  TOTAL_WIDTH  incoming packet
i_data_valid  input  1  incoming packet valid
o_data_ready  output  1  constant 1 (always sinks)
o_done  output  1  high while in DONE
o_sent_count  output  CNT_WIDTH  packets accepted by the router this run
o_recv_count  output  CNT_WIDTH  packets received since reset
o_err_count  output  CNT_WIDTH  received packets whose header != ADDRESS

Behaviour:
- Reset (rst low, asynchronous): state IDLE; o_data_valid=0; o_data=0; o_done=0; all counters 0; seq=0; lfsr=(LFSR_SEED^ADDRESS), or 16'h0001 if that value is 0. Deasserting mid-transfer simply abandons the packet.
- Transfer: a packet is accepted on a clock edge where o_data_valid && i_data_ready. While valid && !ready, o_data and o_data_valid are held stable.
- Payload: (PKT_LIMIT*ADDRESS + seq) truncated to DATA_WIDTH; seq counts 0..PKT_LIMIT-1.
- Destination, mode 0/3: lfsr[15:0] % NUM_PE. LFSR is 16-bit Galois, mask 16'hB400, and advances only on acceptance. Mode 1: i_dest. Mode 2: (ADDRESS+1)%NUM_PE. Mode and dest are sampled when each packet is formed.
- FSM:
  - IDLE: on i_start, clear o_sent_count and seq. If PKT_LIMIT==0 go to DONE; otherwise go to SEND, presenting packet 0 with valid=1 on the next cycle (1-cycle start latency).
  - SEND: on acceptance, o_sent_count++ and seq++.
    - If seq reaches PKT_LIMIT: go to DONE, valid=0.
    - Else if INJ_GAP==0: stay in SEND and present the next packet the following cycle (back-to-back).
    - Else: go to GAP with valid=0 and gap counter = INJ_GAP.
  - GAP: decrement the gap counter each cycle; at 1, go to SEND with the next packet valid. Exactly INJ_GAP cycles have valid=0.
  - DONE: o_done=1. i_start restarts the run as from IDLE. The LFSR is not reseeded, so the sequence continues.
- i_start in SEND/GAP is ignored.
- Receive: every cycle with i_data_valid=1, o_recv_count++. If i_data[DATA_WIDTH+:ADDRESS_WIDTH] != ADDRESS, o_err_count++ as well. Receive operates in all states, independent of the TX FSM; simultaneous TX and RX are fully independent.
- All counters saturate at all-ones; there is no wrap-around.
- Counters are registered outputs, visible one cycle after the event.

Test Plan:
- Defaults, ADDRESS=3, mode 2, i_data_ready=1, i_start pulse -> 100 back-to-back packets; first o_data=36'h4_0000012C, last payload 0x18F. o_sent_count=100, o_done=1 the cycle after the last acceptance.
- INJ_GAP=3, PKT_LIMIT=4, ready held 1 -> valid pattern 1,0,0,0,1,0,0,0,1,0,0,0,1 then DONE; o_sent_count=4.
- Backpressure: ready low for 5 cycles during packet 2 -> o_data is stable and valid stays high throughout; no duplicated or skipped seq; LFSR advances exactly once.
- Mode 0, ADDRESS=0, NUM_PE=12 -> all destinations <12. The sequence matches a reference Galois LFSR seeded 16'hACE1 % 12.
- Inject 7 packets headed 3 and 2 headed 5 into ADDRESS=3 PE, including during TX -> o_recv_count=9, o_err_count=2.
- Reset asserted mid-SEND with ready=0 -> outputs clear immediately (asynchronously); PKT_LIMIT=0 start -> DONE next cycle with o_sent_count=0.
